// File: rtl/pwm_duty_seq.sv
// Duty-pattern sequencer for the 4-channel PWM timer.
// Steps through a small table of per-channel compare sets, switching the
// active set only on PWM period boundaries so channel edges never glitch.
module pwm_duty_seq #(
  parameter int DEPTH     = 8,
  parameter int AW        = $clog2(DEPTH),
  parameter int DW        = 16,
  parameter int CH        = 4,
  parameter int RPT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [CH*DW-1:0]     wr_data_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 loop_i,
  input  logic [AW:0]          len_i,
  input  logic [RPT_WIDTH-1:0] rpt_i,
  input  logic                 period_end_i,
  output logic [CH*DW-1:0]     cr_o,
  output logic                 cr_upd_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  // Pattern table: plain flops, deliberately not reset.
  logic [CH*DW-1:0] tbl [DEPTH];

  // Sequence control state
  state_t               state_q, state_d;
  logic [AW:0]          len_q, len_d;
  logic [RPT_WIDTH-1:0] rpt_q, rpt_d;
  logic                 loop_q, loop_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [RPT_WIDTH-1:0] rpt_cnt_q, rpt_cnt_d;

  // Registered outputs
  logic [CH*DW-1:0]     cr_p1, cr_d;
  logic                 cr_upd_p1, cr_upd_d;
  logic                 busy_p1;
  logic                 done_p1, done_d;
  logic                 err_p1, err_d;

  // Helpers for the entry-advance decision
  logic [AW-1:0]        idx_inc;
  logic [AW:0]          idx_inc_ext;
  logic                 len_ok;

  // Table write port; a same-cycle load still sees the old contents.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tbl[wr_addr_i] <= wr_data_i;
    end
  end

  // Next-state and next-output decode for the IDLE/ARM/RUN sequencer.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rpt_d       = rpt_q;
    loop_d      = loop_q;
    idx_d       = idx_q;
    rpt_cnt_d   = rpt_cnt_q;
    cr_d        = cr_p1;
    cr_upd_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    idx_inc     = idx_q + AW'(1);
    idx_inc_ext = {1'b0, idx_q} + ONE_L;
    len_ok      = (len_i != '0) && (len_i <= DEPTH_L);

    unique case (state_q)
      IDLE: begin
        // start wins over a simultaneous stop; period_end is ignored here
        if (start_i) begin
          if (len_ok) begin
            len_d   = len_i;
            rpt_d   = rpt_i;
            loop_d  = loop_i;
            state_d = ARM;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ARM: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (period_end_i) begin
          cr_d      = tbl[0];
          idx_d     = '0;
          rpt_cnt_d = rpt_q;
          cr_upd_d  = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (period_end_i) begin
          if (rpt_cnt_q != '0) begin
            rpt_cnt_d = rpt_cnt_q - RPT_WIDTH'(1);
          end else if (idx_inc_ext < len_q) begin
            idx_d     = idx_inc;
            cr_d      = tbl[idx_inc];
            rpt_cnt_d = rpt_q;
            cr_upd_d  = 1'b1;
          end else if (loop_q) begin
            idx_d     = '0;
            cr_d      = tbl[0];
            rpt_cnt_d = rpt_q;
            cr_upd_d  = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, control and output registers; async reset clears everything but the table.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      rpt_q     <= '0;
      loop_q    <= 1'b0;
      idx_q     <= '0;
      rpt_cnt_q <= '0;
      cr_p1     <= '0;
      cr_upd_p1 <= 1'b0;
      busy_p1   <= 1'b0;
      done_p1   <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rpt_q     <= rpt_d;
      loop_q    <= loop_d;
      idx_q     <= idx_d;
      rpt_cnt_q <= rpt_cnt_d;
      cr_p1     <= cr_d;
      cr_upd_p1 <= cr_upd_d;
      busy_p1   <= (state_d != IDLE);
      done_p1   <= done_d;
      err_p1    <= err_d;
    end
  end

  assign cr_o     = cr_p1;
  assign cr_upd_o = cr_upd_p1;
  assign busy_o   = busy_p1;
  assign done_o   = done_p1;
  assign err_o    = err_p1;

endmodule

// File: tb/tb_pwm_duty_seq.sv
// Self-checking bench for pwm_duty_seq: reset checks, a vector table for the
// one-shot and rejected-start cases, hand sequences for multi-cycle corners,
// and a randomized run against a period-count reference model.
module tb_pwm_duty_seq;

  localparam int DEPTH     = 8;
  localparam int AW        = 3;
  localparam int DW        = 16;
  localparam int CH        = 4;
  localparam int RPT_WIDTH = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i;
  logic                 wr_en_i;
  logic [AW-1:0]        wr_addr_i;
  logic [CH*DW-1:0]     wr_data_i;
  logic                 start_i;
  logic                 stop_i;
  logic                 loop_i;
  logic [AW:0]          len_i;
  logic [RPT_WIDTH-1:0] rpt_i;
  logic                 period_end_i;
  logic [CH*DW-1:0]     cr_o;
  logic                 cr_upd_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;

  pwm_duty_seq #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .CH(CH), .RPT_WIDTH(RPT_WIDTH)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i),
    .len_i(len_i), .rpt_i(rpt_i), .period_end_i(period_end_i),
    .cr_o(cr_o), .cr_upd_o(cr_upd_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: a sequence is a count of handled periods since arming;
  // slot = p/(rpt+1) picks the entry, phase 0 of each slot is a reload.
  logic [CH*DW-1:0] mtbl [DEPTH];
  bit               m_active;
  int               m_p, m_len, m_rpt;
  bit               m_loop;
  logic [CH*DW-1:0] e_cr;
  bit               e_upd, e_busy, e_done, e_err;

  typedef struct {
    bit               start;
    bit               stop;
    bit               pe;
    bit               loop;
    logic [AW:0]      len;
    logic [7:0]       rpt;
    logic [CH*DW-1:0] x_cr;
    bit               x_upd;
    bit               x_busy;
    bit               x_done;
    bit               x_err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [CH*DW-1:0] rep(input logic [DW-1:0] v);
    return {CH{v}};
  endfunction

  function automatic vec_t mk(input bit st, input bit sp, input bit pe, input bit lp,
                              input logic [AW:0] ln, input logic [7:0] rp,
                              input logic [CH*DW-1:0] cr, input bit upd,
                              input bit busy, input bit done, input bit err);
    vec_t v;
    v.start = st; v.stop = sp; v.pe = pe; v.loop = lp; v.len = ln; v.rpt = rp;
    v.x_cr = cr; v.x_upd = upd; v.x_busy = busy; v.x_done = done; v.x_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_p = 0; m_len = 0; m_rpt = 0; m_loop = 0;
    e_cr = '0; e_upd = 0; e_busy = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_step();
    int slot, phase, ent;
    e_upd = 0; e_done = 0; e_err = 0;
    if (!m_active) begin
      if (start_i) begin
        if (len_i >= 1 && int'(len_i) <= DEPTH) begin
          m_active = 1; m_p = 0;
          m_len = int'(len_i); m_rpt = int'(rpt_i); m_loop = loop_i;
        end else begin
          e_err = 1;
        end
      end
    end else if (stop_i) begin
      m_active = 0;
    end else if (period_end_i) begin
      slot  = m_p / (m_rpt + 1);
      phase = m_p % (m_rpt + 1);
      if (!m_loop && slot >= m_len) begin
        m_active = 0;
        e_done   = 1;
      end else begin
        if (phase == 0) begin
          ent   = m_loop ? (slot % m_len) : slot;
          e_cr  = mtbl[ent];
          e_upd = 1;
        end
        m_p++;
      end
    end
    if (wr_en_i) mtbl[wr_addr_i] = wr_data_i;
    e_busy = m_active;
  endtask

  task automatic clear_pulses();
    start_i = 0; stop_i = 0; period_end_i = 0; wr_en_i = 0;
  endtask

  // Advance one clock with the currently driven inputs and check against the model.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk_i);
    #1;
    chk({tag, " cr"},   cr_o,     e_cr);
    chk({tag, " upd"},  cr_upd_o, e_upd);
    chk({tag, " busy"}, busy_o,   e_busy);
    chk({tag, " done"}, done_o,   e_done);
    chk({tag, " err"},  err_o,    e_err);
    clear_pulses();
  endtask

  task automatic write_tbl(input int a, input logic [CH*DW-1:0] d);
    wr_en_i = 1; wr_addr_i = AW'(a); wr_data_i = d;
    tick("write");
  endtask

  task automatic pe_tick(input string tag);
    period_end_i = 1;
    tick(tag);
  endtask

  task automatic start_seq(input int ln, input int rp, input bit lp);
    start_i = 1; len_i = (AW+1)'(ln); rpt_i = RPT_WIDTH'(rp); loop_i = lp;
    tick("start");
  endtask

  initial begin
    rst_n_i = 0;
    wr_addr_i = '0; wr_data_i = '0; len_i = '0; rpt_i = '0; loop_i = 0;
    clear_pulses();
    model_reset();
    #3;
    chk("reset cr",   cr_o,     '0);
    chk("reset upd",  cr_upd_o, 1'b0);
    chk("reset busy", busy_o,   1'b0);
    chk("reset done", done_o,   1'b0);
    chk("reset err",  err_o,    1'b0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_n_i = 1;

    // Preload: entry k holds 0x10*(k+1) on every channel
    for (int k = 0; k < DEPTH; k++) write_tbl(k, rep(DW'(16'h10 * (k + 1))));

    // One-shot sequence and rejected starts as a vector table
    vecs.push_back(mk(1, 0, 0, 0, 4'd3, 8'd0, '0,          0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd3, 8'd0, rep(16'h10), 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd3, 8'd0, rep(16'h20), 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd3, 8'd0, rep(16'h30), 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4'd3, 8'd0, rep(16'h30), 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'd3, 8'd0, rep(16'h30), 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'd0, 8'd0, rep(16'h30), 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 4'd0, 8'd0, rep(16'h30), 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'd9, 8'd0, rep(16'h30), 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'd9, 8'd0, rep(16'h30), 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 4'd8, 8'd0, rep(16'h30), 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'd8, 8'd0, rep(16'h30), 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 4'd8, 8'd0, rep(16'h30), 0, 0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      start_i = vecs[i].start; stop_i = vecs[i].stop; period_end_i = vecs[i].pe;
      loop_i = vecs[i].loop; len_i = vecs[i].len; rpt_i = vecs[i].rpt;
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d cr", i),   cr_o,     vecs[i].x_cr);
      chk($sformatf("vec%0d upd", i),  cr_upd_o, vecs[i].x_upd);
      chk($sformatf("vec%0d busy", i), busy_o,   vecs[i].x_busy);
      chk($sformatf("vec%0d done", i), done_o,   vecs[i].x_done);
      chk($sformatf("vec%0d err", i),  err_o,    vecs[i].x_err);
    end

    // Repeat count: len=2, rpt=2 -> reloads on periods 1 and 4, done on 7
    start_seq(2, 2, 0);
    for (int p = 1; p <= 7; p++) begin
      pe_tick($sformatf("rpt p%0d", p));
      chk($sformatf("rpt upd p%0d", p),  cr_upd_o, (p == 1 || p == 4));
      chk($sformatf("rpt done p%0d", p), done_o,   (p == 7));
      chk($sformatf("rpt cr p%0d", p),   cr_o,     (p < 4) ? rep(16'h10) : rep(16'h20));
    end

    // Loop then stop coinciding with period_end
    start_seq(2, 0, 1);
    for (int p = 1; p <= 5; p++) begin
      pe_tick($sformatf("loop p%0d", p));
      chk($sformatf("loop cr p%0d", p), cr_o, (p % 2 == 1) ? rep(16'h10) : rep(16'h20));
      chk($sformatf("loop upd p%0d", p), cr_upd_o, 1'b1);
    end
    stop_i = 1; period_end_i = 1;
    tick("stop");
    chk("stop cr",   cr_o,     rep(16'h10));
    chk("stop upd",  cr_upd_o, 1'b0);
    chk("stop busy", busy_o,   1'b0);
    chk("stop done", done_o,   1'b0);

    // Write hazard: writing entry 1 while it is being loaded yields the old data
    write_tbl(1, rep(16'h55));
    start_seq(2, 0, 0);
    pe_tick("haz e0");
    wr_en_i = 1; wr_addr_i = AW'(1); wr_data_i = rep(16'hAA);
    pe_tick("haz e1");
    chk("haz old cr", cr_o, rep(16'h55));
    pe_tick("haz end");
    chk("haz done", done_o, 1'b1);
    start_seq(2, 0, 0);
    pe_tick("haz2 e0");
    pe_tick("haz2 e1");
    chk("haz new cr", cr_o, rep(16'hAA));
    chk("haz new upd", cr_upd_o, 1'b1);
    pe_tick("haz2 end");

    // Async reset mid-RUN, no clock edge between assertion and the check
    start_seq(3, 1, 1);
    pe_tick("ar p1");
    pe_tick("ar p2");
    pe_tick("ar p3");
    #2;
    rst_n_i = 0;
    #1;
    chk("async cr",   cr_o,     '0);
    chk("async upd",  cr_upd_o, 1'b0);
    chk("async busy", busy_o,   1'b0);
    chk("async done", done_o,   1'b0);
    chk("async err",  err_o,    1'b0);
    model_reset();
    @(posedge clk_i); #1;
    rst_n_i = 1;
    start_seq(1, 0, 0);
    pe_tick("post rst e0");
    chk("post rst cr", cr_o, rep(16'h10));
    pe_tick("post rst end");
    chk("post rst done", done_o, 1'b1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      start_i      = ($urandom_range(0, 15) == 0);
      stop_i       = ($urandom_range(0, 49) == 0);
      period_end_i = ($urandom_range(0, 2) == 0);
      loop_i       = $urandom_range(0, 1);
      len_i        = (AW+1)'($urandom_range(0, 15));
      rpt_i        = RPT_WIDTH'($urandom_range(0, 3));
      wr_en_i      = ($urandom_range(0, 3) == 0);
      wr_addr_i    = AW'($urandom_range(0, DEPTH - 1));
      wr_data_i    = {$urandom, $urandom};
      tick($sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_duty_seq.md
# pwm_duty_seq

Duty-pattern sequencer for the 4-channel PWM timer. It holds a small table of per-channel compare values and steps through them, updating the active compare set only on PWM period boundaries, so channel edges never glitch mid-period. It sits between the bus-side configuration logic and the PWM compare registers. It consumes the timer's period-end pulse and produces compare values plus a load strobe.

## Interface
Parameters:
- DEPTH, 8, number of pattern-table entries; must be a power of 2, ≥2
- AW, $clog2(DEPTH), table address width
- DW, 16, compare width per channel; matches the PWM CRx width
- CH, 4, number of PWM channels
- RPT_WIDTH, 8, repeat-count width

Ports:
- clk_i  in  1  bus clock; the only clock
- rst_n_i  in  1  reset, asynchronous, active-low
- wr_en_i  in  1  table write strobe
- wr_addr_i  in  AW  table write address
- wr_data_i  in  CH*DW  entry data; channel n occupies bits [n*DW +: DW]
- start_i  in  1  start pulse
- stop_i  in  1  abort pulse
- loop_i  in  1  1 = restart at entry 0 after the last entry; 0 = one-shot
- len_i  in  AW+1  number of active entries; valid range 1..DEPTH
- rpt_i  in  RPT_WIDTH  each entry is held for rpt_i+1 periods
- period_end_i  in  1  one-cycle pulse on PWM counter wrap; clk_i domain
- cr_o  out  CH*DW  current compare set driven to the PWM
- cr_upd_o  out  1  one-cycle strobe; cr_o changed this cycle
- busy_o  out  1  sequence active (state ≠ IDLE)
- done_o  out  1  one-cycle pulse when a one-shot sequence completes
- err_o  out  1  one-cycle pulse when start_i is rejected because len_i is out of range

## Operation
- Table: flop array of DEPTH × CH*DW, no reset.
  - A write with wr_en_i takes effect at the next clock edge, in any state.
  - A load in the same cycle as a write to the same address reads the old contents (no forwarding).
- start_i latches len_i, rpt_i and loop_i. Later changes to these inputs have no effect until the next start.
- State machine: IDLE, ARM, RUN.
- IDLE:
  - start_i with 1 ≤ len_i ≤ DEPTH → ARM.
  - start_i with len_i = 0 or len_i > DEPTH → stay in IDLE and pulse err_o.
- ARM, on period_end_i:
  - cr_o ← table[0]; idx ← 0; rpt_cnt ← rpt; cr_upd_o pulses.
  - → RUN.
- RUN, on period_end_i:
  - If rpt_cnt ≠ 0: rpt_cnt ← rpt_cnt − 1; no update.
  - Else, if idx < len−1: idx ← idx+1; cr_o ← table[idx+1]; rpt_cnt ← rpt; cr_upd_o pulses.
  - Else, if loop: idx ← 0; cr_o ← table[0]; rpt_cnt ← rpt; cr_upd_o pulses.
  - Else (one-shot end): → IDLE; done_o pulses; cr_o holds the last entry.
- stop_i in ARM or RUN:
  - → IDLE; cr_o holds its value; no done_o, no cr_upd_o.
  - stop_i wins over a simultaneous period_end_i.
- start_i outside IDLE is ignored. start_i and stop_i together in IDLE: start is honoured.
- period_end_i in IDLE is ignored.
- rpt_cnt is RPT_WIDTH bits and never wraps; the decrement happens only when rpt_cnt ≠ 0.
- idx is AW bits; len is compared at width AW+1.

## Timing
- Reset values: cr_o = 0, cr_upd_o = 0, busy_o = 0, done_o = 0, err_o = 0; state = IDLE, idx = 0, rpt_cnt = 0.
- All outputs are registered.
- cr_o and cr_upd_o change in the cycle after period_end_i is sampled (latency 1).
- busy_o rises in the cycle after an accepted start_i and falls in the cycle after stop_i or the final period_end_i.
- done_o asserts in the same cycle that busy_o falls.
- err_o asserts the cycle after a rejected start_i.
- Back-to-back period_end_i pulses on consecutive cycles are each processed.
- A new start_i is accepted in the first IDLE cycle after done_o.
- Reset asserted mid-sequence returns all state and outputs to their reset values immediately; table contents are undefined.

## Test plan
- One-shot sequence:
  - Stimulus: table[0..2] = {0x10,0x20,0x30} replicated across channels; len=3, rpt=0, loop=0; start, then 4 period_end pulses.
  - Response: cr_upd_o pulses 3 times with cr_o = 0x10, 0x20, 0x30; done_o pulses after the 4th pulse; cr_o stays 0x30; busy_o = 0.
- Repeat count:
  - Stimulus: len=2, rpt=2.
  - Response: each entry holds for 3 periods; cr_upd_o only on periods 1 and 4; done_o on period 7.
- Loop and stop:
  - Stimulus: len=2, loop=1, rpt=0; 5 periods, then stop_i in the same cycle as period_end_i.
  - Response: cr_o walks e0, e1, e0, e1, e0; after stop, no update, busy_o = 0, done_o stays 0.
- Rejected start:
  - Stimulus: start with len=0, then with len=DEPTH+1.
  - Response: err_o pulses each time; busy_o stays 0; cr_o unchanged.
- Write hazard:
  - Stimulus: write table[1]=0xAA in the same cycle as the period_end_i that loads entry 1 (old value 0x55).
  - Response: cr_o = 0x55; after a restart, entry 1 loads 0xAA.
- Async reset mid-RUN:
  - Stimulus: assert rst_n_i low mid-RUN.
  - Response: all outputs go to 0 without a clock edge; after release, start works normally.
